// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared states, constants and helpers for the UART receive capture block
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam int DATA_BITS   = 8;
    localparam int SYNC_STAGES = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO with registered head (rx_data/rx_valid) and push/pop in one cycle
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [DATA_BITS-1:0] i_push_data,
    input  logic                 i_pop,
    output logic                 o_full,
    output logic                 o_valid,
    output logic [DATA_BITS-1:0] o_data
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_valid;
    logic [DATA_BITS-1:0] r_data;

    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic [PTR_W-1:0]     w_rd_next;
    logic [CNT_W-1:0]     w_count_next;
    logic [DATA_BITS-1:0] w_head_next;

    assign w_full    = (r_count == DEPTH_C);
    assign w_pop     = i_pop && r_valid;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push    = i_push && (!w_full || w_pop);
    assign w_rd_next = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

    // The slot the head moves to may be the one being written right now.
    assign w_head_next = (w_push && (r_wr_ptr == w_rd_next)) ? i_push_data : r_mem[w_rd_next];

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            if (w_count_next != '0) begin
                r_data <= w_head_next;
            end
        end
    end

    assign o_full  = w_full;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/uart_rx_capture.sv
// rtl/uart_rx_capture.sv - 8N1 UART receiver with byte FIFO; define UART_RX_PARITY_EN for 8E1 with parity_err
module uart_rx_capture
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 io_mainClk,
    input  logic                 io_asyncResetn,
    input  logic                 io_uart_txd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 overrun_clr
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam logic [15:0] HALF_M1  = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0] FULL_M1  = 16'(CLK_DIV - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic [15:0]            r_bit_cnt;
    logic [2:0]             r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_frame_err;
    logic                   r_overrun;

    logic                   w_rxs;
    logic                   w_at_half;
    logic                   w_at_full;
    logic                   w_cnt_clr;
    logic                   w_shift_en;
    logic                   w_stop_ok;
    logic                   w_frame_err_set;
    logic                   w_push_req;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_overrun_set;

`ifdef UART_RX_PARITY_EN
    logic                   r_par_bad;
    logic                   r_parity_err;
    logic                   w_par_check;
    logic                   w_par_fail;
`endif

    assign w_rxs     = r_sync[SYNC_STAGES-1];
    assign w_at_half = (r_bit_cnt == HALF_M1);
    assign w_at_full = (r_bit_cnt == FULL_M1);

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], io_uart_txd};
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_clr       = 1'b0;
        w_shift_en      = 1'b0;
        w_stop_ok       = 1'b0;
        w_frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_check     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rxs) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                // Mid-start-bit recheck rejects short glitches on the idle line.
                if (w_at_half) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = w_rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_at_full) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_at_full) begin
                    w_cnt_clr    = 1'b1;
                    w_par_check  = 1'b1;
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leaving at mid-stop-bit lets a start bit that follows immediately be caught.
                if (w_at_full) begin
                    w_cnt_clr = 1'b1;
                    if (w_rxs) begin
                        w_stop_ok    = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_frame_err_set = 1'b1;
                        w_state_next    = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                w_cnt_clr = 1'b1;
                if (w_rxs) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_cnt_clr    = 1'b1;
                w_state_next = ST_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign w_par_fail = ^{r_shift, w_rxs};
    assign w_push_req = w_stop_ok && !r_par_bad;
`else
    assign w_push_req = w_stop_ok;
`endif

    assign w_pop         = rx_valid && rx_ready;
    assign w_overrun_set = w_push_req && w_fifo_full && !w_pop;

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_cnt_clr ? 16'd0 : (r_bit_cnt + 16'd1);
            r_frame_err <= w_frame_err_set;
            if (r_state != ST_DATA) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_par_check && w_par_fail;
            if (w_par_check) begin
                r_par_bad <= w_par_fail;
            end
        end
    end

    assign parity_err = r_parity_err;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (io_mainClk),
        .rst_n       (io_asyncResetn),
        .i_push      (w_push_req),
        .i_push_data (r_shift),
        .i_pop       (rx_ready),
        .o_full      (w_fifo_full),
        .o_valid     (rx_valid),
        .o_data      (rx_data)
    );

    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_capture.sv
// tb/tb_uart_rx_capture.sv - frame-level reference model and per-cycle compare for uart_rx_capture
module tb_uart_rx_capture;

    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS   = 1;
    localparam int LAT_LIT    = 171;
`else
    localparam int PAR_BITS   = 0;
    localparam int LAT_LIT    = 155;
`endif
    // Edge at which the stop bit is judged, counted from the edge the start bit is driven after.
    localparam int STOP_EDGE  = 2 + CLK_DIV / 2 + (9 + PAR_BITS) * CLK_DIV + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       txd;
    logic       rx_ready;
    logic       overrun_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    always #5 clk = ~clk;

    uart_rx_capture #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .io_mainClk     (clk),
        .io_asyncResetn (rst_n),
        .io_uart_txd    (txd),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .frame_err      (frame_err),
        .overrun        (overrun),
        .overrun_clr    (overrun_clr)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err     (parity_err)
`endif
    );

    typedef struct {
        longint     edge_n;
        logic [7:0] data;
        bit         stop_ok;
        bit         par_ok;
    } frame_ev_t;

    frame_ev_t  ev_q[$];
    logic [7:0] m_fifo[$];
    logic [7:0] got[$];
    longint     cyc = 0;
    longint     last_rise = 0;
    bit         m_valid = 0;
    bit         m_fe = 0;
    bit         m_ovr = 0;
    bit         m_pe = 0;
    logic [7:0] m_data = 8'h00;
    bit         checking = 0;
    bit         prev_valid = 0;
    bit         rnd_done = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         fe_seen = 0;
    int         pe_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_got(input string name, input logic [7:0] exp[$]);
        check({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check(name, (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF_FFFF, {24'd0, exp[i]});
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        ev_q.delete();
        m_valid = 0;
        m_data  = 8'h00;
        m_fe    = 0;
        m_ovr   = 0;
        m_pe    = 0;
    endtask

    // Frame-level model: each recorded frame resolves at its stop-sample edge.
    task automatic model_step();
        frame_ev_t ev;
        bit        ovr_set;
        ovr_set = 0;
        m_fe    = 0;
        m_pe    = 0;
        if (m_valid && rx_ready) begin
            void'(m_fifo.pop_front());
        end
`ifdef UART_RX_PARITY_EN
        if (ev_q.size() > 0 && ev_q[0].edge_n - CLK_DIV == cyc && !ev_q[0].par_ok) begin
            m_pe = 1;
        end
`endif
        if (ev_q.size() > 0 && ev_q[0].edge_n == cyc) begin
            ev = ev_q.pop_front();
            if (!ev.stop_ok) begin
                m_fe = 1;
            end else if (ev.par_ok) begin
                if (m_fifo.size() < FIFO_DEPTH) begin
                    m_fifo.push_back(ev.data);
                end else begin
                    ovr_set = 1;
                end
            end
        end
        if (ovr_set) begin
            m_ovr = 1;
        end else if (overrun_clr) begin
            m_ovr = 0;
        end
        m_valid = (m_fifo.size() != 0);
        if (m_valid) begin
            m_data = m_fifo[0];
        end
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("rx_valid", rx_valid, m_valid);
            check("rx_data", rx_data, m_data);
            check("frame_err", frame_err, m_fe);
            check("overrun", overrun, m_ovr);
`ifdef UART_RX_PARITY_EN
            check("parity_err", parity_err, m_pe);
`endif
        end
        if (rst_n) begin
            if (rx_valid && rx_ready) got.push_back(rx_data);
            if (frame_err) fe_seen++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_seen++;
`endif
            if (rx_valid && !prev_valid) last_rise = cyc;
        end
        prev_valid = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        txd = b;
        tick(CLK_DIV);
    endtask

    // Called aligned just after a rising edge; returns aligned the same way.
    task automatic send_frame(input logic [7:0] data, input bit stop_bit, input bit par_good,
                              input int low_after, input bit record, output longint s);
        s = cyc;
        if (record) begin
            ev_q.push_back('{edge_n: s + STOP_EDGE, data: data, stop_ok: stop_bit, par_ok: par_good});
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_bit(data[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit((^data) ^ !par_good);
`endif
        drive_bit(stop_bit);
        if (low_after > 0) begin
            txd = 1'b0;
            tick(low_after);
        end
        txd = 1'b1;
    endtask

    initial begin
        logic [7:0] exp[$];
        longint     s;
        rst_n       = 1'b1;
        txd         = 1'b1;
        rx_ready    = 1'b0;
        overrun_clr = 1'b0;
        #1 rst_n = 1'b0;
        tick(3);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        rst_n    = 1'b1;
        checking = 1;
        tick(5);

        rx_ready = 1'b1;
        got.delete();
        fe_seen = 0;
        send_frame(8'hA5, 1, 1, 0, 1, s);
        tick(10);
        check("basic_latency", last_rise - s, LAT_LIT);
        exp = '{8'hA5};
        check_got("basic_byte", exp);
        check("basic_no_frame_err", fe_seen, 0);

        got.delete();
        fe_seen = 0;
        txd = 1'b0;
        tick(4);
        txd = 1'b1;
        tick(40);
        check("glitch_no_byte", got.size(), 0);
        check("glitch_no_frame_err", fe_seen, 0);

        got.delete();
        fe_seen = 0;
        send_frame(8'h3C, 0, 1, 40, 1, s);
        tick(8);
        send_frame(8'h81, 1, 1, 0, 1, s);
        tick(10);
        check("framing_pulses", fe_seen, 1);
        exp = '{8'h81};
        check_got("framing_bytes", exp);

        rx_ready = 1'b0;
        got.delete();
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 1, 1, 0, 1, s);
        end
        tick(5);
        check("overrun_set", overrun, 1'b1);
        check("overrun_head", rx_data, 8'h01);
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        check("overrun_cleared", overrun, 1'b0);
        rx_ready = 1'b1;
        tick(10);
        exp = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_got("overrun_drain", exp);

        rx_ready = 1'b0;
        got.delete();
        for (int b = 1; b <= 4; b++) begin
            send_frame(8'(b), 1, 1, 0, 1, s);
        end
        fork
            send_frame(8'h05, 1, 1, 0, 1, s);
            begin
                tick(STOP_EDGE - 1);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
            end
        join
        tick(5);
        check("fullpop_no_overrun", overrun, 1'b0);
        rx_ready = 1'b1;
        tick(10);
        exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_got("fullpop_order", exp);

`ifdef UART_RX_PARITY_EN
        got.delete();
        pe_seen = 0;
        send_frame(8'h07, 1, 0, 0, 1, s);
        tick(10);
        check("parity_pulse", pe_seen, 1);
        check("parity_no_byte", got.size(), 0);
`endif

        rx_ready = 1'b0;
        send_frame(8'h11, 1, 1, 0, 1, s);
        tick(5);
        check("prereset_valid", rx_valid, 1'b1);
        txd = 1'b0;
        tick(CLK_DIV);
        txd = 1'b1;
        tick(3 * CLK_DIV + CLK_DIV / 2);
        rst_n = 1'b0;
        #1;
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_rx_valid", rx_valid, 1'b0);
        check("midreset_frame_err", frame_err, 1'b0);
        check("midreset_overrun", overrun, 1'b0);
        @(posedge clk);
        #1;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        rx_ready = 1'b1;
        got.delete();
        fe_seen = 0;
        send_frame(8'h5A, 1, 1, 0, 1, s);
        tick(10);
        exp = '{8'h5A};
        check_got("postreset_byte", exp);
        check("postreset_no_frame_err", fe_seen, 0);

        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    bit stop_ok;
                    bit par_ok;
                    stop_ok = ($urandom_range(0, 7) != 0);
                    par_ok  = (PAR_BITS == 0) || ($urandom_range(0, 7) != 0);
                    if (stop_ok) begin
                        send_frame(8'($urandom_range(0, 255)), 1, par_ok, 0, 1, s);
                        tick($urandom_range(0, 12));
                    end else begin
                        send_frame(8'($urandom_range(0, 255)), 0, par_ok, $urandom_range(0, 30), 1, s);
                        tick(2 + $urandom_range(0, 10));
                    end
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    rx_ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        rx_ready = 1'b1;
        tick(40);
        check("final_empty", rx_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
- Serial receiver for the far end of the Murax UART: decodes the 8N1 stream Murax drives on io_uart_txd.
- Buffers received bytes in a small FIFO and presents them on a valid/ready byte port.
- Used by host-side board logic and by test harnesses to observe SoC console output in hardware.

Parameters:
- CLK_DIV, 868, io_mainClk cycles per bit (100 MHz / 115200); legal range 8..65535.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16.

Ports:
- io_mainClk  input  1  sole clock; all logic rising-edge.
- io_asyncResetn  input  1  asynchronous active-low reset.
- io_uart_txd  input  1  serial line from Murax TX; idle high; asynchronous to io_mainClk.
- rx_data  output  8  FIFO head byte.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Reset (async assert, sync-style deassert irrelevant to the block): synchronizer flops = 1, state IDLE, counters 0, FIFO empty. Outputs: rx_data 0x00, rx_valid 0, frame_err 0, overrun 0.
- io_uart_txd passes through a 2-flop synchronizer (reset value 1); all decoding uses the synchronized value "rxs".
- Bit counter: 16 bits, counts 0..CLK_DIV-1.
- IDLE:
  - rxs==0 -> START, bit counter cleared.
- START:
  - At count CLK_DIV/2-1 (integer division), sample rxs.
  - rxs==1 -> IDLE (glitch rejected, no flag).
  - rxs==0 -> DATA, counter cleared, bit index 0.
- DATA:
  - At each count CLK_DIV-1, shift rxs into the shift register LSB-first (bit 0 first) and clear the counter.
  - After bit index 7 -> STOP (or PARITY, see Optional Feature).
- STOP: at count CLK_DIV-1, sample rxs.
  - rxs==1 and FIFO not full: push byte -> IDLE.
  - rxs==1 and FIFO full: byte dropped, overrun set -> IDLE.
  - rxs==0: frame_err pulses for exactly 1 cycle, byte discarded -> BREAK.
- BREAK:
  - Wait until rxs==1 -> IDLE; no new start detected while the line is held low.
- Returning to IDLE at mid-stop-bit is required so back-to-back frames with no idle gap are received.
- FIFO:
  - Push and pop in the same cycle: both take effect; count unchanged, including when full.
  - If full, a pop in the same cycle as a push means no overrun.
  - rx_data and rx_valid are registered from the FIFO head and update the cycle after push or pop.
  - rx_data holds its last value while empty.
- overrun: set and overrun_clr in the same cycle -> set wins.
- Latency:
  - rx_valid rises 1 cycle after the STOP-sample cycle.
  - Total from the line falling edge = 2 + CLK_DIV/2 + 9*CLK_DIV + 1 cycles, ±1 synchronizer uncertainty.
- Reset mid-frame: partial byte discarded, FIFO emptied, no frame_err.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: PARITY state after DATA samples 1 bit at mid-bit.
  - Extra output parity_err: 1-cycle pulse when XOR(data, parity bit) != 0; byte discarded; STOP state still runs.
  - Latency grows by CLK_DIV.
- Undefined: 8N1 only; parity_err port absent.

Decomposition:
- Shared package uart_rx_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - constants DATA_BITS=8, SYNC_STAGES=2;
  - function clog2 for FIFO pointer width.
- Sub-module uart_rx_fifo: FIFO_DEPTH x 8 synchronous FIFO with push/pop/full/empty and registered head.
- The FSM, synchronizer and bit counter stay in the top.

Test Plan:
- Basic byte, CLK_DIV=16, rx_ready=1: send 0xA5 8N1 -> rx_valid pulses once with rx_data=0xA5 at the stated latency; frame_err=0.
- Glitch: low pulse of 4 cycles on an idle line -> no byte, no frame_err, state returns to IDLE.
- Framing: send 0x3C with stop bit 0, line held low 40 cycles, then 0x81 -> frame_err pulses once, only 0x81 is delivered.
- Overrun, FIFO_DEPTH=4, rx_ready=0: send 0x01..0x05 back-to-back -> FIFO holds 0x01..0x04, overrun=1.
  - Then overrun_clr for 1 cycle -> overrun=0.
  - Then drain -> exactly 4 bytes in order.
- Full + simultaneous pop: FIFO full, rx_ready=1 on the cycle the 5th STOP is sampled -> no overrun, 0x05 delivered after 0x04.
- Reset mid-frame: assert io_asyncResetn=0 during bit 3 of 0xFF -> all outputs 0 immediately; the next clean 0x5A is received correctly.
  - With UART_RX_PARITY_EN: 0x07 with wrong parity -> parity_err pulse, no byte delivered.
